// File: rtl/iter_div_unit_pkg.sv
// Shared definitions for the iterative divider: FSM state encoding and nominal latency.
package iter_div_unit_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    CALC = 2'b01,
    FIX  = 2'b10,
    DONE = 2'b11
  } div_state_e;

  localparam int DIV_DW  = 32;
  // Accept edge to out_valid on the normal path: DW iterations, one fixup, one output register.
  localparam int DIV_LAT = DIV_DW + 2;

endpackage

// File: rtl/iter_div_unit_sign_fix.sv
// Combinational sign handling for the divider: operand magnitudes going in,
// signed quotient/remainder reconstruction coming out.
module div_sign_fix
  import iter_div_unit_pkg::*;
#(
  parameter int DW = 32
) (
  input  logic          is_unsign,
  input  logic [DW-1:0] dividend,
  input  logic [DW-1:0] divisor,
  output logic          a_sign,
  output logic          b_sign,
  output logic [DW-1:0] a_mag,
  output logic [DW-1:0] b_mag,
  input  logic [DW-1:0] q_mag,
  input  logic [DW-1:0] r_mag,
  input  logic          q_neg,
  input  logic          r_neg,
  output logic [DW-1:0] quotient,
  output logic [DW-1:0] remainder
);

  // Operand signs and magnitudes; unsigned operands pass straight through.
  always_comb begin
    a_sign = ~is_unsign & dividend[DW-1];
    b_sign = ~is_unsign & divisor[DW-1];
    if (a_sign) begin
      a_mag = ~dividend + {{(DW-1){1'b0}}, 1'b1};
    end else begin
      a_mag = dividend;
    end
    if (b_sign) begin
      b_mag = ~divisor + {{(DW-1){1'b0}}, 1'b1};
    end else begin
      b_mag = divisor;
    end
  end

  // Reapply result signs computed from the registered operand signs.
  always_comb begin
    if (q_neg) begin
      quotient = ~q_mag + {{(DW-1){1'b0}}, 1'b1};
    end else begin
      quotient = q_mag;
    end
    if (r_neg) begin
      remainder = ~r_mag + {{(DW-1){1'b0}}, 1'b1};
    end else begin
      remainder = r_mag;
    end
  end

endmodule

// File: rtl/iter_div_unit.sv
// Iterative radix-2 non-restoring divider (DIV/DIVU/REM/REMU) with valid/ready handshakes.
// Optional feature macro DIV_EARLY_OUT_EN: short-circuit when |dividend| < |divisor|.
module iter_div_unit
  import iter_div_unit_pkg::*;
#(
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic          is_unsign,
  input  logic [DW-1:0] dividend,
  input  logic [DW-1:0] divisor,
  input  logic          flush,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] quotient,
  output logic [DW-1:0] remainder,
  output logic          div_zero
);

  localparam int CW = $clog2(DW);
  localparam logic [DW-1:0] MIN_NEG  = {1'b1, {(DW-1){1'b0}}};
  localparam logic [CW-1:0] CNT_LAST = CW'(DW - 1);

  div_state_e state_r, state_nxt_s;

  logic [DW:0]   rem_r;
  logic [DW-1:0] quo_r;
  logic [DW-1:0] dvs_r;
  logic [CW-1:0] cnt_r;
  logic          a_sign_r, b_sign_r, uns_r;
  logic [DW-1:0] quotient_r, remainder_r;
  logic          div_zero_r, out_valid_r;

  logic          in_ready_s, accept_s, calc_en_s, fix_en_s, out_valid_nxt_s;
  logic          a_sign_s, b_sign_s;
  logic [DW-1:0] a_mag_s, b_mag_s;
  logic          dz_s, ovf_s, early_s, short_s, short_dz_s;
  logic [DW-1:0] short_q_s, short_r_s;
  logic [DW:0]   shift_s, rem_step_s, rem_fix_s;
  logic [DW-1:0] quo_step_s;
  logic [DW-1:0] fix_q_s, fix_r_s;
  logic          cnt_last_s;

  div_sign_fix #(.DW(DW)) u_sign_fix (
    .is_unsign (is_unsign),
    .dividend  (dividend),
    .divisor   (divisor),
    .a_sign    (a_sign_s),
    .b_sign    (b_sign_s),
    .a_mag     (a_mag_s),
    .b_mag     (b_mag_s),
    .q_mag     (quo_r),
    .r_mag     (rem_fix_s[DW-1:0]),
    .q_neg     (~uns_r & (a_sign_r ^ b_sign_r)),
    .r_neg     (~uns_r & a_sign_r),
    .quotient  (fix_q_s),
    .remainder (fix_r_s)
  );

  assign dz_s  = (divisor == {DW{1'b0}});
  assign ovf_s = ~is_unsign & (dividend == MIN_NEG) & (divisor == {DW{1'b1}});
`ifdef DIV_EARLY_OUT_EN
  assign early_s = (a_mag_s < b_mag_s);
`else
  assign early_s = 1'b0;
`endif

  // Requests resolved at accept time, bypassing the iteration; divide-by-zero has priority.
  always_comb begin
    short_s    = 1'b0;
    short_dz_s = 1'b0;
    short_q_s  = {DW{1'b0}};
    short_r_s  = {DW{1'b0}};
    if (dz_s) begin
      short_s    = 1'b1;
      short_dz_s = 1'b1;
      short_q_s  = {DW{1'b1}};
      short_r_s  = dividend;
    end else if (ovf_s) begin
      short_s   = 1'b1;
      short_q_s = dividend;
    end else if (early_s) begin
      short_s   = 1'b1;
      short_r_s = dividend;
    end else begin
      short_s = 1'b0;
    end
  end

  // One non-restoring step; the wrap of the DW+1-bit remainder cancels because the true value stays in [-D, D).
  always_comb begin
    shift_s    = {rem_r[DW-1:0], quo_r[DW-1]};
    if (rem_r[DW]) begin
      rem_step_s = shift_s + {1'b0, dvs_r};
    end else begin
      rem_step_s = shift_s - {1'b0, dvs_r};
    end
    quo_step_s = {quo_r[DW-2:0], ~rem_step_s[DW]};
    if (rem_r[DW]) begin
      rem_fix_s = rem_r + {1'b0, dvs_r};
    end else begin
      rem_fix_s = rem_r;
    end
    cnt_last_s = (cnt_r == CNT_LAST);
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // FSM next-state logic; flush overrides every state.
  always_comb begin
    state_nxt_s = state_r;
    if (flush) begin
      state_nxt_s = IDLE;
    end else begin
      case (state_r)
        IDLE: begin
          if (accept_s) begin
            state_nxt_s = short_s ? DONE : CALC;
          end else begin
            state_nxt_s = IDLE;
          end
        end
        CALC:    state_nxt_s = cnt_last_s ? FIX : CALC;
        FIX:     state_nxt_s = DONE;
        DONE: begin
          if (out_valid_r && out_ready) begin
            state_nxt_s = IDLE;
          end else begin
            state_nxt_s = DONE;
          end
        end
        default: state_nxt_s = IDLE;
      endcase
    end
  end

  // FSM outputs: handshake and datapath enables.
  always_comb begin
    in_ready_s      = 1'b0;
    accept_s        = 1'b0;
    calc_en_s       = 1'b0;
    fix_en_s        = 1'b0;
    out_valid_nxt_s = 1'b0;
    case (state_r)
      IDLE: begin
        in_ready_s = 1'b1;
        accept_s   = in_valid & ~flush;
      end
      CALC:    calc_en_s = ~flush;
      FIX:     fix_en_s  = ~flush;
      DONE:    out_valid_nxt_s = ~flush & ~(out_valid_r & out_ready);
      default: in_ready_s = 1'b0;
    endcase
  end

  // Operand capture and iteration state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rem_r    <= {(DW+1){1'b0}};
      quo_r    <= {DW{1'b0}};
      dvs_r    <= {DW{1'b0}};
      cnt_r    <= {CW{1'b0}};
      a_sign_r <= 1'b0;
      b_sign_r <= 1'b0;
      uns_r    <= 1'b0;
    end else if (accept_s) begin
      rem_r    <= {(DW+1){1'b0}};
      quo_r    <= a_mag_s;
      dvs_r    <= b_mag_s;
      cnt_r    <= {CW{1'b0}};
      a_sign_r <= a_sign_s;
      b_sign_r <= b_sign_s;
      uns_r    <= is_unsign;
    end else if (calc_en_s) begin
      rem_r <= rem_step_s;
      quo_r <= quo_step_s;
      cnt_r <= cnt_r + 1'b1;
    end
  end

  // Result registers, loaded either at a short-path accept or in FIX, then held through DONE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      quotient_r  <= {DW{1'b0}};
      remainder_r <= {DW{1'b0}};
      div_zero_r  <= 1'b0;
    end else if (accept_s && short_s) begin
      quotient_r  <= short_q_s;
      remainder_r <= short_r_s;
      div_zero_r  <= short_dz_s;
    end else if (fix_en_s) begin
      quotient_r  <= fix_q_s;
      remainder_r <= fix_r_s;
      div_zero_r  <= 1'b0;
    end
  end

  // out_valid lags entry into DONE by one cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_r <= 1'b0;
    end else begin
      out_valid_r <= out_valid_nxt_s;
    end
  end

  assign in_ready  = in_ready_s;
  assign out_valid = out_valid_r;
  assign quotient  = quotient_r;
  assign remainder = remainder_r;
  assign div_zero  = div_zero_r;

endmodule

// File: tb/tb_iter_div_unit.sv
// Directed self-checking bench for iter_div_unit (DW = 32), hand-computed expectations.
module tb_iter_div_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_ready, is_unsign, flush;
  logic [31:0] dividend, divisor;
  logic        out_valid, out_ready;
  logic [31:0] quotient, remainder;
  logic        div_zero;

  int n_vec = 0;
  int n_bad = 0;

  localparam int LAT_NORM  = 34;
  localparam int LAT_SHORT = 1;
`ifdef DIV_EARLY_OUT_EN
  localparam int LAT_LT = 1;
`else
  localparam int LAT_LT = 34;
`endif

  always #5 clk = ~clk;

  iter_div_unit #(.DW(32)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .is_unsign (is_unsign),
    .dividend  (dividend),
    .divisor   (divisor),
    .flush     (flush),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .quotient  (quotient),
    .remainder (remainder),
    .div_zero  (div_zero)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Present a request and hold it until accepted; returns cycles spent waiting for in_ready.
  task automatic start_op(input logic uns, input logic [31:0] a, input logic [31:0] b, output int waited);
    is_unsign = uns;
    dividend  = a;
    divisor   = b;
    in_valid  = 1'b1;
    waited    = 0;
    while (!in_ready && waited < 200) begin
      @(posedge clk); #1;
      waited++;
    end
    check("accept_bound", (waited < 200), 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_result(input string tag, input logic [31:0] eq, input logic [31:0] er,
                             input logic edz, input int elat);
    int lat;
    lat = 0;
    while (!out_valid && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
    check({tag, "_lat"}, lat, elat);
    check({tag, "_q"}, quotient, eq);
    check({tag, "_r"}, remainder, er);
    check({tag, "_dz"}, div_zero, edz);
  endtask

  task automatic drain();
    @(posedge clk); #1;
    check("drain_valid", out_valid, 0);
    check("drain_ready", in_ready, 1);
  endtask

  task automatic run(input string tag, input logic uns, input logic [31:0] a, input logic [31:0] b,
                     input logic [31:0] eq, input logic [31:0] er, input logic edz, input int elat);
    int w;
    start_op(uns, a, b, w);
    wait_result(tag, eq, er, edz, elat);
    drain();
  endtask

  initial begin
    int w;
    int seen;
    rst_n = 1'b0; in_valid = 1'b0; is_unsign = 1'b0; flush = 1'b0;
    dividend = 32'd0; divisor = 32'd0; out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_ready", in_ready, 1);
    check("rst_valid", out_valid, 0);
    check("rst_q", quotient, 0);
    check("rst_r", remainder, 0);
    check("rst_dz", div_zero, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("post_rst_ready", in_ready, 1);

    run("neg11_3", 1'b0, 32'hFFFF_FFF5, 32'd3, 32'hFFFF_FFFD, 32'hFFFF_FFFE, 1'b0, LAT_NORM);

    // Back-to-back: second request is already waiting while the first result is handshaken.
    start_op(1'b0, 32'd10, 32'd5, w);
    wait_result("b2b_1", 32'd2, 32'd0, 1'b0, LAT_NORM);
    check("b2b_ready_in_done", in_ready, 0);
    start_op(1'b0, 32'd128, 32'd13, w);
    check("b2b_gap", (w >= 1), 1);
    wait_result("b2b_2", 32'd9, 32'd11, 1'b0, LAT_NORM);
    drain();

    run("div0_pos", 1'b0, 32'd7, 32'd0, 32'hFFFF_FFFF, 32'd7, 1'b1, LAT_SHORT);
    run("div0_neg", 1'b0, 32'hFFFF_FFF9, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFF9, 1'b1, LAT_SHORT);
    run("ovf", 1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0, 1'b0, LAT_SHORT);
    run("p11_m3", 1'b0, 32'd11, 32'hFFFF_FFFD, 32'hFFFF_FFFD, 32'd2, 1'b0, LAT_NORM);
    run("min_by_1", 1'b0, 32'h8000_0000, 32'd1, 32'h8000_0000, 32'd0, 1'b0, LAT_NORM);
    run("u_lt", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000, 1'b0, LAT_LT);
    run("s_lt", 1'b0, 32'hFFFF_FFFB, 32'd7, 32'd0, 32'hFFFF_FFFB, 1'b0, LAT_LT);

    // Consumer stall: results must hold while out_ready is low.
    out_ready = 1'b0;
    start_op(1'b1, 32'hFFFF_FFF5, 32'd3, w);
    wait_result("u_stall", 32'h5555_5551, 32'd2, 1'b0, LAT_NORM);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      check("stall_valid", out_valid, 1);
      check("stall_q", quotient, 32'h5555_5551);
      check("stall_r", remainder, 32'd2);
    end
    out_ready = 1'b1;
    drain();

    // Flush ten cycles into CALC.
    start_op(1'b0, 32'd100, 32'd3, w);
    repeat (10) begin
      @(posedge clk); #1;
    end
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    check("flush_idle", in_ready, 1);
    check("flush_valid", out_valid, 0);
    seen = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (out_valid) seen++;
    end
    check("flush_no_result", seen, 0);

    // Flush coincident with a request blocks the accept.
    is_unsign = 1'b0; dividend = 32'd9; divisor = 32'd0;
    in_valid = 1'b1; flush = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0; flush = 1'b0;
    check("flush_blk_ready", in_ready, 1);
    @(posedge clk); #1;
    check("flush_blk_valid", out_valid, 0);

    run("after_flush", 1'b0, 32'd5, 32'd7, 32'd0, 32'd5, 1'b0, LAT_LT);

    // Reset in the middle of an operation.
    start_op(1'b0, 32'd1000, 32'd7, w);
    repeat (5) begin
      @(posedge clk); #1;
    end
    rst_n = 1'b0;
    #1;
    check("midrst_ready", in_ready, 1);
    check("midrst_valid", out_valid, 0);
    check("midrst_q", quotient, 0);
    #2;
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("midrst_release_ready", in_ready, 1);
    run("after_rst", 1'b0, 32'd1000, 32'd7, 32'd142, 32'd6, 1'b0, LAT_NORM);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
